// File: rtl/addr_map_decoder_pkg.sv
// Shared SoC address-map package: rule record, default memory map and helpers.
package addr_map_decoder_pkg;

  localparam int SocAddrWidth   = 64;
  localparam int DefaultNrRules = 5;

  // One address window: [base, base + len).
  typedef struct packed {
    logic [SocAddrWidth-1:0] base;
    logic [SocAddrWidth-1:0] len;
  } rule_t;

  // Default SoC map, one window per rule index 0..4.
  localparam rule_t RuleDebugMap = '{base: 64'h0000_0000_0000_0000, len: 64'h0000_0000_0000_1000};
  localparam rule_t RuleClintMap = '{base: 64'h0000_0000_0200_0000, len: 64'h0000_0000_000C_0000};
  localparam rule_t RulePlicMap  = '{base: 64'h0000_0000_0C00_0000, len: 64'h0000_0000_0400_0000};
  localparam rule_t RuleExtIoMap = '{base: 64'h0000_0000_4000_0000, len: 64'h0000_0000_1000_0000};
  localparam rule_t RuleDramMap  = '{base: 64'h0000_0000_8000_0000, len: 64'h0000_0000_4000_0000};

  // Packed per-rule tables, element [i] belongs to rule i.
  localparam logic [DefaultNrRules-1:0][SocAddrWidth-1:0] DefaultRuleBase = {
    RuleDramMap.base, RuleExtIoMap.base, RulePlicMap.base, RuleClintMap.base, RuleDebugMap.base
  };
  localparam logic [DefaultNrRules-1:0][SocAddrWidth-1:0] DefaultRuleLength = {
    RuleDramMap.len, RuleExtIoMap.len, RulePlicMap.len, RuleClintMap.len, RuleDebugMap.len
  };

  // Rule index width; a single-rule map still gets a 1-bit index.
  function automatic int idx_width(input int nr_rules);
    return (nr_rules > 1) ? $clog2(nr_rules) : 1;
  endfunction

endpackage

// File: rtl/addr_map_decoder_if.sv
// Request/response, rule-configuration and status bundle of the address decoder.
interface addr_map_decoder_if
  import addr_map_decoder_pkg::*;
#(
  parameter int NrRules   = DefaultNrRules,
  parameter int AddrWidth = SocAddrWidth
) ();

  localparam int IdxWidth = idx_width(NrRules);

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [IdxWidth-1:0]  rsp_idx_o;
  logic                 rsp_decerr_o;
  logic                 cfg_we_i;
  logic [IdxWidth-1:0]  cfg_idx_i;
  logic [AddrWidth-1:0] cfg_base_i;
  logic [AddrWidth-1:0] cfg_len_i;
  logic                 cfg_lock_i;
  logic                 locked_o;
  logic [15:0]          miss_cnt_o;

  // Requester / configuration side.
  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i,
    output cfg_we_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_lock_i,
    input  req_ready_o, rsp_valid_o, rsp_idx_o, rsp_decerr_o, locked_o, miss_cnt_o
  );

  // Decoder side.
  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i,
    input  cfg_we_i, cfg_idx_i, cfg_base_i, cfg_len_i, cfg_lock_i,
    output req_ready_o, rsp_valid_o, rsp_idx_o, rsp_decerr_o, locked_o, miss_cnt_o
  );

endinterface

// File: rtl/addr_rule_match.sv
// Single-rule window comparator (purely combinational).
module addr_rule_match #(
  parameter int AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] base,
  input  logic [AddrWidth-1:0] len,
  input  logic [AddrWidth-1:0] addr,
  output logic                 hit
);

  // One extra bit keeps base + len from wrapping at the top of the address space.
  logic [AddrWidth:0] end_excl;

  assign end_excl = {1'b0, base} + {1'b0, len};

  // Empty windows never match.
  assign hit = (len != '0) && (addr >= base) && ({1'b0, addr} < end_excl);

endmodule

// File: rtl/addr_map_decoder.sv
// Address-map decoder: programmable rule table, priority match, one-deep response register.
module addr_map_decoder
  import addr_map_decoder_pkg::*;
#(
  parameter int NrRules   = DefaultNrRules,
  parameter int AddrWidth = SocAddrWidth,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RuleBaseInit   = DefaultRuleBase,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RuleLengthInit = DefaultRuleLength
) (
  input logic             clk_i,
  input logic             rst_i,
  addr_map_decoder_if.slave bus
);

  localparam int IdxWidth = idx_width(NrRules);

  logic [NrRules-1:0][AddrWidth-1:0] base_reg;
  logic [NrRules-1:0][AddrWidth-1:0] len_reg;
  logic [NrRules-1:0]                hit;
  logic [IdxWidth-1:0]               win_idx;
  logic                              any_hit;
  logic                              req_ready;
  logic                              accept;
  logic                              cfg_write;
  logic                              locked_reg;
  logic                              rsp_valid_reg;
  logic [IdxWidth-1:0]               rsp_idx_reg;
  logic                              rsp_decerr_reg;
  logic [15:0]                       miss_cnt_reg;

  // The output register can take a new response whenever it is empty or being drained.
  assign req_ready = ~rsp_valid_reg | bus.rsp_ready_i;
  assign accept    = bus.req_valid_i & req_ready;

  // Writes to a non-existent rule, or after locking, are dropped.
  assign cfg_write = bus.cfg_we_i & ~locked_reg & (int'(bus.cfg_idx_i) < NrRules);

  // One comparator per rule, all looking at the live request address.
  for (genvar gi = 0; gi < NrRules; gi++) begin : g_rule
    addr_rule_match #(
      .AddrWidth (AddrWidth)
    ) u_match (
      .base (base_reg[gi]),
      .len  (len_reg[gi]),
      .addr (bus.req_addr_i),
      .hit  (hit[gi])
    );
  end

  // Lowest matching index wins; no match leaves index 0.
  always_comb begin
    win_idx = '0;
    any_hit = 1'b0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_idx = IdxWidth'(i);
        any_hit = 1'b1;
      end
    end
  end

  // Rule table; a write issued alongside a request only affects later requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_reg <= RuleBaseInit;
      len_reg  <= RuleLengthInit;
    end else if (cfg_write) begin
      base_reg[bus.cfg_idx_i] <= bus.cfg_base_i;
      len_reg[bus.cfg_idx_i]  <= bus.cfg_len_i;
    end
  end

  // Sticky lock; the write check above uses the old value, so write-then-lock falls out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked_reg <= 1'b0;
    end else if (bus.cfg_lock_i) begin
      locked_reg <= 1'b1;
    end
  end

  // Response register: loads when ready, holds its payload while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_reg  <= 1'b0;
      rsp_idx_reg    <= '0;
      rsp_decerr_reg <= 1'b0;
    end else if (req_ready) begin
      rsp_valid_reg <= bus.req_valid_i;
      if (bus.req_valid_i) begin
        rsp_idx_reg    <= win_idx;
        rsp_decerr_reg <= ~any_hit;
      end
    end
  end

  // Saturating count of accepted requests that hit no rule.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_cnt_reg <= '0;
    end else if (accept && !any_hit && (miss_cnt_reg != 16'hFFFF)) begin
      miss_cnt_reg <= miss_cnt_reg + 16'd1;
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.rsp_valid_o  = rsp_valid_reg;
  assign bus.rsp_idx_o    = rsp_idx_reg;
  assign bus.rsp_decerr_o = rsp_decerr_reg;
  assign bus.locked_o     = locked_reg;
  assign bus.miss_cnt_o   = miss_cnt_reg;

endmodule

// File: tb/tb_addr_map_decoder.sv
// Directed bench for addr_map_decoder with the default five-rule SoC map.
module tb_addr_map_decoder;

  logic clk_i;
  logic rst_i;
  int   tests_run;
  int   tests_failed;

  addr_map_decoder_if #(.NrRules(5), .AddrWidth(64)) bus ();

  addr_map_decoder dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic vld, input logic [2:0] idx, input logic err);
    check_eq({tag, "_valid"},  64'(bus.rsp_valid_o),  64'(vld));
    check_eq({tag, "_idx"},    64'(bus.rsp_idx_o),    64'(idx));
    check_eq({tag, "_decerr"}, 64'(bus.rsp_decerr_o), 64'(err));
  endtask

  // Back-to-back vectors against the default map.
  logic [63:0] b2b_addr [8] = '{64'h0, 64'h0200_0000, 64'h0C00_0000, 64'h4000_0000,
                                64'hBFFF_FFFF, 64'hC000_0000, 64'h0000_1000, 64'h020B_FFFF};
  logic [2:0]  b2b_idx  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd1};
  logic        b2b_err  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_i            = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = '0;
    bus.rsp_ready_i  = 1'b1;
    bus.cfg_we_i     = 1'b0;
    bus.cfg_idx_i    = '0;
    bus.cfg_base_i   = '0;
    bus.cfg_len_i    = '0;
    bus.cfg_lock_i   = 1'b0;
    step();
    step();
    rst_i = 1'b0;

    // Reset state.
    check_rsp("reset", 1'b0, 3'd0, 1'b0);
    check_eq("reset_locked", 64'(bus.locked_o), 64'd0);
    check_eq("reset_miss", 64'(bus.miss_cnt_o), 64'd0);
    check_eq("reset_ready", 64'(bus.req_ready_o), 64'd1);

    // DRAM hit, then a hole in the map.
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h8000_0010;
    step();
    check_rsp("dram", 1'b1, 3'd4, 1'b0);
    bus.req_addr_i = 64'h0300_0000;
    step();
    check_rsp("hole", 1'b1, 3'd0, 1'b1);
    check_eq("hole_miss", 64'(bus.miss_cnt_o), 64'd1);

    // Eight requests back-to-back, one response per cycle in order.
    for (int i = 0; i < 8; i++) begin
      bus.req_addr_i = b2b_addr[i];
      step();
      check_rsp($sformatf("b2b%0d", i), 1'b1, b2b_idx[i], b2b_err[i]);
    end
    bus.req_valid_i = 1'b0;
    step();
    check_eq("b2b_drain_valid", 64'(bus.rsp_valid_o), 64'd0);
    check_eq("b2b_miss", 64'(bus.miss_cnt_o), 64'd3);

    // Stall the response for three cycles with a second request waiting.
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h0C00_0010;
    step();
    check_rsp("stall_a", 1'b1, 3'd2, 1'b0);
    bus.rsp_ready_i = 1'b0;
    bus.req_addr_i  = 64'h4000_0000;
    #1;
    check_eq("stall_ready", 64'(bus.req_ready_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_rsp($sformatf("stall_hold%0d", i), 1'b1, 3'd2, 1'b0);
      check_eq($sformatf("stall_ready%0d", i), 64'(bus.req_ready_o), 64'd0);
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    check_eq("stall_release_ready", 64'(bus.req_ready_o), 64'd1);
    step();
    check_rsp("stall_b", 1'b1, 3'd3, 1'b0);
    bus.req_valid_i = 1'b0;
    step();
    check_eq("stall_drain_valid", 64'(bus.rsp_valid_o), 64'd0);

    // Rule write in the same cycle as a request: the request still sees the old
    // table, where DRAM (rule 4) covers 0x9000_0000; the next one sees rule 1.
    bus.cfg_we_i    = 1'b1;
    bus.cfg_idx_i   = 3'd1;
    bus.cfg_base_i  = 64'h9000_0000;
    bus.cfg_len_i   = 64'h1000;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h9000_0000;
    step();
    bus.cfg_we_i = 1'b0;
    check_rsp("cfg_same", 1'b1, 3'd4, 1'b0);
    step();
    check_rsp("cfg_next", 1'b1, 3'd1, 1'b0);

    // Zero-length rule never matches.
    bus.req_valid_i = 1'b0;
    bus.cfg_we_i    = 1'b1;
    bus.cfg_idx_i   = 3'd0;
    bus.cfg_base_i  = 64'h0;
    bus.cfg_len_i   = 64'h0;
    step();
    bus.cfg_we_i    = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h0;
    step();
    check_rsp("len0", 1'b1, 3'd0, 1'b1);
    bus.req_valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;

    // Lock, then a write that must be ignored.
    bus.cfg_lock_i = 1'b1;
    step();
    bus.cfg_lock_i = 1'b0;
    check_eq("lock_set", 64'(bus.locked_o), 64'd1);
    bus.cfg_we_i   = 1'b1;
    bus.cfg_idx_i  = 3'd0;
    bus.cfg_base_i = 64'h0;
    bus.cfg_len_i  = 64'h0;
    step();
    bus.cfg_we_i    = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h0;
    step();
    check_rsp("locked_wr", 1'b1, 3'd0, 1'b0);
    check_eq("lock_held", 64'(bus.locked_o), 64'd1);

    // Reset while a response is stalled discards it and clears the lock.
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_eq("midrst_valid", 64'(bus.rsp_valid_o), 64'd0);
    check_eq("midrst_locked", 64'(bus.locked_o), 64'd0);
    check_eq("midrst_ready", 64'(bus.req_ready_o), 64'd1);
    bus.rsp_ready_i = 1'b1;

    // Write and lock together: the write lands, then the table freezes.
    bus.cfg_we_i   = 1'b1;
    bus.cfg_lock_i = 1'b1;
    bus.cfg_idx_i  = 3'd3;
    bus.cfg_base_i = 64'hFFFF_FFFF_FFFF_F000;
    bus.cfg_len_i  = 64'h1000;
    step();
    bus.cfg_we_i   = 1'b0;
    bus.cfg_lock_i = 1'b0;
    check_eq("wl_locked", 64'(bus.locked_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check_rsp("top", 1'b1, 3'd3, 1'b0);
    bus.req_addr_i = 64'hFFFF_FFFF_FFFF_EFFF;
    step();
    check_rsp("below_top", 1'b1, 3'd0, 1'b1);

    // Miss counter saturation.
    bus.req_valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 64'h0300_0000;
    repeat (65534) step();
    check_eq("sat_fffe", 64'(bus.miss_cnt_o), 64'hFFFE);
    step();
    check_eq("sat_ffff", 64'(bus.miss_cnt_o), 64'hFFFF);
    repeat (4) step();
    check_eq("sat_hold", 64'(bus.miss_cnt_o), 64'hFFFF);
    bus.req_valid_i = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
